// File: rtl/hex_display_arbiter_if.sv
// -----------------------------------------------------------------------------
// hex_display_arbiter_if
// Groups the requester-side and display-side signals of hex_display_arbiter.
//
// Protocol: a requester asserts req[i] as a level for as long as it wants
// screen time and keeps its word on data_in[64*i +: 64]. There is no ready
// back to requesters: grant[i] tells source i it is on screen. The display
// driver samples data_out continuously and needs no handshake.
//
// Signals:
//   req          requester -> arbiter  per-source request level
//   data_in      requester -> arbiter  source words, source i at [64*i +: 64]
//   step         requester -> arbiter  one-cycle pulse, advance now
//   freeze       requester -> arbiter  level, hold the current grant
//   data_out     arbiter -> driver     registered word on screen
//   grant        arbiter -> requester  one-hot owner, zero when idle
//   active       arbiter -> requester  some source is granted
//   switch_pulse arbiter -> requester  one cycle on every owner change
//   dbg_state    arbiter -> observer   current FSM state (0 IDLE, 1 SHOW)
//
// N_SRC must match the N_SRC of the hex_display_arbiter it connects to.
// -----------------------------------------------------------------------------
interface hex_display_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]    req;
  logic [64*N_SRC-1:0] data_in;
  logic                step;
  logic                freeze;
  logic [63:0]         data_out;
  logic [N_SRC-1:0]    grant;
  logic                active;
  logic                switch_pulse;
  logic                dbg_state;

  modport slave (
    input  req, data_in, step, freeze,
    output data_out, grant, active, switch_pulse, dbg_state
  );

  modport master (
    output req, data_in, step, freeze,
    input  data_out, grant, active, switch_pulse, dbg_state
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// -----------------------------------------------------------------------------
// hex_display_arbiter
// Time-shares one 16-digit hex display between N_SRC requesters. Sources are
// granted round-robin; each grant lasts DWELL_CYCLES clocks, or ends early on
// a step pulse. freeze pauses the dwell counter and masks step. A source that
// drops its request loses the screen immediately, even while frozen.
//
// Ports:
//   clock_27mhz  system clock
//   reset        asynchronous active-high reset
//   bus          hex_display_arbiter_if.slave (req, data_in, step, freeze in;
//                data_out, grant, active, switch_pulse, dbg_state out)
//
// Parameters:
//   N_SRC         number of requesters, 2..8
//   DWELL_CYCLES  clocks per grant, >= 2
//   CNT_W         dwell counter width, 2**CNT_W > DWELL_CYCLES
//
// Build option:
//   HEXARB_PAGE_TAG_EN  when defined, data_out[63:60] shows the owner index so
//                       the leftmost digit identifies the source on screen.
//                       When undefined, data_out is the unmodified source word.
// -----------------------------------------------------------------------------
module hex_display_arbiter #(
  parameter int N_SRC        = 4,
  parameter int DWELL_CYCLES = 27000000,
  parameter int CNT_W        = 25
) (
  input  logic                  clock_27mhz,
  input  logic                  reset,
  hex_display_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_SRC = IDX_W'(N_SRC - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;      // current owner, or last owner when idle
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      data_q, data_d;
  logic             pulse_q, pulse_d;

  logic [IDX_W-1:0] next_idx;
  logic             any_req;
  logic             owner_req;
  logic             advance;
  logic [63:0]      src_word;
  logic [63:0]      shown_word;
  logic [N_SRC-1:0] grant_onehot;

  // Round-robin search: nearest requester after ptr_q, wrapping, with ptr_q
  // itself last. The outer loop matches the pointer so every index is a
  // constant; the inner loop runs far-to-near so the nearest hit wins.
  always_comb begin
    next_idx = ptr_q;
    for (int p = 0; p < N_SRC; p++) begin
      if (ptr_q == IDX_W'(p)) begin
        for (int k = N_SRC; k >= 1; k--) begin
          if (bus.req[(p + k) % N_SRC]) begin
            next_idx = IDX_W'((p + k) % N_SRC);
          end
        end
      end
    end
  end

  assign any_req = |bus.req;

  // Owner's request bit, owner's word and the one-hot grant decode.
  always_comb begin
    owner_req    = 1'b0;
    src_word     = 64'h0;
    grant_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ptr_q == IDX_W'(i)) begin
        owner_req       = bus.req[i];
        src_word        = bus.data_in[64*i +: 64];
        grant_onehot[i] = 1'b1;
      end
    end
  end

`ifdef HEXARB_PAGE_TAG_EN
  assign shown_word = {4'(ptr_q), src_word[59:0]};
`else
  assign shown_word = src_word;
`endif

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pulse_d = 1'b0;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        data_d = 64'h0;
        if (any_req) begin
          state_d = SHOW;
          ptr_d   = next_idx;
          cnt_d   = RELOAD;
          pulse_d = 1'b1;
        end
      end

      SHOW: begin
        // Registered every cycle so live source updates reach the display;
        // after an owner change this still shows the old owner for one cycle.
        data_d = shown_word;

        // Losing the request beats freeze; step and expiry share one advance.
        if (!owner_req) begin
          advance = 1'b1;
        end else if (!bus.freeze && bus.step) begin
          advance = 1'b1;
        end else if (!bus.freeze && (cnt_q == '0)) begin
          advance = 1'b1;
        end

        if (advance) begin
          if (!any_req) begin
            state_d = IDLE;
            data_d  = 64'h0;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            // A sole requester re-wins itself: reload only, no pulse.
            ptr_d   = next_idx;
            cnt_d   = RELOAD;
            pulse_d = (next_idx != ptr_q);
          end
        end else if (!bus.freeze) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= LAST_SRC;
      cnt_q   <= '0;
      data_q  <= 64'h0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.data_out     = data_q;
  assign bus.grant        = (state_q == SHOW) ? grant_onehot : '0;
  assign bus.active       = (state_q == SHOW);
  assign bus.switch_pulse = pulse_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hex_display_arbiter
// Directed bench for hex_display_arbiter with N_SRC=4, DWELL_CYCLES=8.
// Stimulus pushes {expected cycle, grant, data} for every owner change it
// causes; the monitor pops one entry per switch_pulse, checks grant and the
// cycle it arrived in, then checks data_out one cycle later.
// -----------------------------------------------------------------------------
module tb_hex_display_arbiter;

  localparam int N_SRC = 4;
  localparam int DWELL = 8;
  localparam int EW    = 32 + N_SRC + 64;

  logic clock_27mhz = 1'b0;
  logic reset;

  hex_display_arbiter_if #(.N_SRC(N_SRC)) bus ();

  hex_display_arbiter #(
    .N_SRC        (N_SRC),
    .DWELL_CYCLES (DWELL),
    .CNT_W        (4)
  ) dut (
    .clock_27mhz (clock_27mhz),
    .reset       (reset),
    .bus         (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock_27mhz = ~clock_27mhz;

  int cyc = 0;
  always @(posedge clock_27mhz) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          pend = 1'b0;
  logic [63:0]   pend_val = 64'h0;

  function automatic logic [63:0] raw_word(input int i);
    logic [63:0] w;
    w = 64'h1111_1111_1111_1111 * 64'(i + 1);
    return w;
  endfunction

  function automatic logic [63:0] exp_word(input int i);
    logic [63:0] w;
    w = raw_word(i);
`ifdef HEXARB_PAGE_TAG_EN
    w[63:60] = 4'(i);
`endif
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_switch(input int dc, input logic [3:0] g,
                             input logic [63:0] d);
    exp_q.push_back({32'(cyc + dc), g, d});
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock_27mhz);
  endtask

  task automatic do_reset();
    @(negedge clock_27mhz);
    reset = 1'b1;
    exp_q.delete();
    pend = 1'b0;
    @(negedge clock_27mhz);
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_loop();
    logic [EW-1:0] e;
    forever begin
      @(negedge clock_27mhz);
      if (!reset) begin
        if (pend) begin
          check("data_out_after_switch", bus.data_out, pend_val);
          pend = 1'b0;
        end
        if (bus.switch_pulse) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_switch actual grant=%b required no switch (cycle %0d)",
                     bus.grant, cyc);
          end else begin
            e = exp_q.pop_front();
            check("switch_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
            check("switch_grant", 64'(bus.grant), 64'(e[64 +: N_SRC]));
            check("switch_active", 64'(bus.active), 64'(e[64 +: N_SRC] != '0));
            pend     = 1'b1;
            pend_val = e[63:0];
          end
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    bus.req     = '0;
    bus.step    = 1'b0;
    bus.freeze  = 1'b0;
    bus.data_in = {raw_word(3), raw_word(2), raw_word(1), raw_word(0)};

    fork
      monitor_loop();
    join_none

    // Reset state.
    wait_neg(2);
    check("reset_data_out", bus.data_out, 64'h0);
    check("reset_grant", 64'(bus.grant), 64'h0);
    check("reset_active", 64'(bus.active), 64'h0);
    check("reset_switch", 64'(bus.switch_pulse), 64'h0);

    // Test 1: grant source 0, then async reset between clock edges.
    reset   = 1'b0;
    bus.req = 4'b0001;
    push_switch(1, 4'b0001, exp_word(0));
    wait_neg(4);
    @(posedge clock_27mhz);
    #3;
    reset = 1'b1;
    exp_q.delete();
    pend = 1'b0;
    #1;
    check("async_rst_data_out", bus.data_out, 64'h0);
    check("async_rst_grant", 64'(bus.grant), 64'h0);
    check("async_rst_active", 64'(bus.active), 64'h0);
    check("async_rst_switch", 64'(bus.switch_pulse), 64'h0);
    @(negedge clock_27mhz);
    reset = 1'b0;
    push_switch(1, 4'b0001, exp_word(0));
    wait_neg(1);
    check("rerelease_grant", 64'(bus.grant), 64'h1);
    wait_neg(2);
    bus.req = 4'b0000;
    push_switch(1, 4'b0000, 64'h0);
    wait_neg(3);

    // Test 2: all sources, dwell expiry rotation.
    do_reset();
    bus.req = 4'b1111;
    push_switch(1,  4'b0001, exp_word(0));
    push_switch(9,  4'b0010, exp_word(1));
    push_switch(17, 4'b0100, exp_word(2));
    push_switch(25, 4'b1000, exp_word(3));
    push_switch(33, 4'b0001, exp_word(0));
    wait_neg(34);
    bus.req = 4'b0000;
    push_switch(1, 4'b0000, 64'h0);
    wait_neg(3);

    // Test 3: req=0101, early step, then step coinciding with expiry.
    do_reset();
    bus.req = 4'b0101;
    push_switch(1, 4'b0001, exp_word(0));
    wait_neg(4);
    bus.step = 1'b1;
    push_switch(1, 4'b0100, exp_word(2));
    wait_neg(1);
    bus.step = 1'b0;
    push_switch(8, 4'b0001, exp_word(0));
    wait_neg(15);
    // Counter of source 0 is at 0 here: step and expiry give one advance.
    bus.step = 1'b1;
    push_switch(1, 4'b0100, exp_word(2));
    wait_neg(1);
    bus.step = 1'b0;

    // Test 4: freeze for 20 cycles with counter at 4, steps ignored.
    wait_neg(3);
    bus.freeze = 1'b1;
    wait_neg(6);
    bus.step = 1'b1;
    wait_neg(1);
    bus.step = 1'b0;
    wait_neg(9);
    bus.step = 1'b1;
    wait_neg(1);
    bus.step = 1'b0;
    wait_neg(3);
    check("freeze_hold_grant", 64'(bus.grant), 64'h4);
    bus.freeze = 1'b0;
    push_switch(5, 4'b0001, exp_word(0));
    wait_neg(6);
    bus.req = 4'b0000;
    push_switch(1, 4'b0000, 64'h0);
    wait_neg(3);

    // Step while idle is ignored.
    bus.step = 1'b1;
    wait_neg(1);
    bus.step = 1'b0;
    wait_neg(2);
    check("idle_step_active", 64'(bus.active), 64'h0);

    // Test 5: sole requester keeps the screen, then drops.
    bus.req = 4'b0010;
    push_switch(1, 4'b0010, exp_word(1));
    wait_neg(26);
    check("sole_grant", 64'(bus.grant), 64'h2);
    check("sole_data_out", bus.data_out, exp_word(1));
    bus.req = 4'b0000;
    push_switch(1, 4'b0000, 64'h0);
    wait_neg(1);
    check("drop_grant", 64'(bus.grant), 64'h0);
    check("drop_active", 64'(bus.active), 64'h0);
    check("drop_data_out", bus.data_out, 64'h0);
    check("drop_switch", 64'(bus.switch_pulse), 64'h1);
    wait_neg(3);

    // Every expected switch must have been observed.
    check("pending_switches", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
Shares the single 16-digit hex display driver among up to N_SRC requesters, such as debug registers, score and tracking data.
Grants one requester at a time round-robin. Each grant lasts a dwell interval, or ends early on a manual step pulse.
Registers the granted requester's 64-bit word onto data_out, which feeds the display driver's 64-bit data input. The driver re-samples it every refresh, so no handshake is needed on the driver side.

Parameters:
N_SRC, 4, number of requesters (2..8)
DWELL_CYCLES, 27000000, clock cycles per grant (1 s at 27 MHz); must be >= 2
CNT_W, 25, dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES

Ports:
clock_27mhz  in  1  system clock
reset  in  1  asynchronous active-high reset
req  in  N_SRC  per-source request level; source i is eligible while req[i]=1
data_in  in  64*N_SRC  source i's word is data_in[64*i+63 : 64*i]
step  in  1  single-cycle pulse (already debounced/synchronised); advance to next eligible source now
freeze  in  1  level; holds the current grant (dwell counter paused, step ignored)
data_out  out  64  word presented to the display driver
grant  out  N_SRC  one-hot current owner; all zero when idle
active  out  1  1 while some source is granted
switch_pulse  out  1  one-cycle pulse on every grant change, including IDLE->grant and grant->IDLE

Behaviour:
- Reset (asynchronous, effective immediately):
  - data_out=0, grant=0, active=0, switch_pulse=0, dwell counter=0, state=IDLE.
  - Last-owner pointer = N_SRC-1, so the first search starts at source 0.
- Next-eligible search (combinational): the first i with req[i]=1, scanning from pointer+1 upward with wrap-around, ending at pointer itself. So the current owner is chosen only when no other source requests.
- State IDLE:
  - grant=0, active=0, data_out held at 0.
  - If req != 0: latch the search result into grant and pointer, load counter=DWELL_CYCLES-1, pulse switch_pulse, go to SHOW.
  - Grant becomes visible 1 cycle after req rises.
- State SHOW:
  - Every cycle: data_out <= granted slice of data_in. One-cycle latency; the output tracks live source changes.
  - Counter decrements when freeze=0 and holds when freeze=1.
- Advance condition, first match wins:
  - (a) req[owner]=0: advance regardless of freeze.
  - (b) freeze=0 and step=1.
  - (c) freeze=0 and counter==0.
- Advance action:
  - If req==0: go to IDLE, grant=0, data_out<=0, pulse switch_pulse.
  - Else: owner=search result, counter reloads to DWELL_CYCLES-1, transition to the new owner's data on the next cycle.
  - switch_pulse fires only if the owner actually changed. A sole requester re-granted to itself gets a counter reload and no pulse.
- step and counter==0 in the same cycle: one advance only.
- step while in IDLE: ignored.
- Request dropping at the exact advance cycle: the search uses the current-cycle req.
- A grant is never given to a source whose req is 0 in the deciding cycle.
- data_in width arithmetic: slice index = owner*64, where owner is an encoded index of width clog2(N_SRC); grant is its one-hot decode.

Optional Feature:
Macro: HEXARB_PAGE_TAG_EN
- Defined: data_out[63:60] is replaced with the owner index (4'h0..4'h7) and data_out[59:0] carries the source's bits [59:0]. The leftmost display digit thus shows which source is on screen. In IDLE, data_out=0 as usual.
- Undefined: data_out is the full 64-bit source word with no modification.

Test Plan (DWELL_CYCLES=8, N_SRC=4, data_in[i]=64'h1111_1111_1111_1111*(i+1)):
1. Reset asserted mid-SHOW, asynchronously between clock edges -> data_out, grant, active, switch_pulse go to 0 without a clock edge; after release, req=4'b0001 gives grant=0001 one cycle later.
2. req=4'b1111 held, no step -> grant sequence 0001, 0010, 0100, 1000, 0001, changing every 8 cycles; switch_pulse on each change; data_out=64'h1111..., 2222..., 3333..., 4444... with 1-cycle lag.
3. req=4'b0101, step pulsed 3 cycles after a grant to source 0 -> grant=0100 on the next cycle with the counter reloaded; source 1 and source 3 are never granted.
4. freeze=1 during grant of source 2 for 20 cycles with step pulses -> grant stays 0100, no switch_pulse; after freeze drops, the change happens after exactly the remaining dwell count.
5. Only req[1]=1 for 24 cycles -> grant stays 0010 with no switch_pulse after the first; drop req[1] -> next cycle grant=0, active=0, data_out=0, switch_pulse=1.
6. With HEXARB_PAGE_TAG_EN defined, source 3 granted -> data_out=64'h3444_4444_4444_4444; undefined -> 64'h4444_4444_4444_4444.
